thread_scheduler: RTL
=====================

# thread_scheduler

Two-thread scheduler for the multithreaded MIPS core. It owns the thread-control ID that indexes the 64-entry, thread-partitioned register file, and it decides each cycle which hardware thread may fetch. Threads switch on a long-latency event (switch-on-event) or when a time quantum expires. Each switch inserts a drain window, so writebacks from the outgoing thread still complete under its own thread ID.

## Interface
Parameters:
- QUANTUM, 64, run cycles before a timeout switch is allowed (≥2)
- SWITCH_CYCLES, 3, drain cycles per switch (≥1; must cover fetch-to-writeback depth)
- QW, $clog2(QUANTUM), quantum counter width
- SW, $clog2(SWITCH_CYCLES+1), drain counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_thread_en  in  2  per-thread enable (level)
- i_block  in  1  current thread hit a long-latency event this cycle (e.g. cache miss)
- i_wake  in  2  per-thread wake pulse (event resolved)
- i_hold  in  1  pipeline stall; freezes the quantum counter and defers timeout switches
- o_thread_id  out  1  thread ID driven into thread_control_ifc
- o_thread_valid  out  1  fetch/issue allowed for o_thread_id
- o_switch  out  1  one-cycle pulse on the first drain cycle (front-end flush)
- o_next_thread  out  1  switch target; equals o_thread_id outside SWITCH
- o_blocked  out  2  per-thread blocked flags

## Operation
- All outputs are registered.
- Reset values: state IDLE, o_thread_id 0, o_next_thread 0, o_thread_valid 0, o_switch 0, o_blocked 00, quantum and drain counters 0.
- cur = o_thread_id; oth = ~cur.
- runnable[t] = i_thread_en[t] & ~o_blocked[t], evaluated on registered flags. A wake takes effect one cycle later.
- Blocked flags:
  - i_block in RUN sets blocked[cur].
  - i_wake[t] clears blocked[t].
  - If set and clear hit the same thread in the same cycle, set wins.
  - ~i_thread_en[t] forces blocked[t] to 0.
- IDLE (valid 0):
  - runnable[cur] → RUN on cur, no drain, qcnt 0.
  - Else runnable[oth] → SWITCH to oth.
  - Else stay in IDLE.
- RUN (valid 1), priority order:
  1. i_block or ~i_thread_en[cur] → SWITCH to oth if runnable[oth], else IDLE.
  2. qcnt == QUANTUM-1 and ~i_hold and runnable[oth] → SWITCH to oth.
  3. Otherwise stay in RUN.
  - qcnt increments when ~i_hold and saturates at QUANTUM-1. A saturated counter causes a switch on the first cycle that oth is runnable and i_hold is low.
- SWITCH (valid 0):
  - On entry: o_next_thread = target, dcnt = SWITCH_CYCLES, o_switch = 1 for the entry cycle only.
  - o_thread_id keeps the old ID for the whole drain window.
  - dcnt decrements each cycle, ignoring i_hold.
  - When dcnt reaches 1:
    - Target still enabled and not blocked → RUN with o_thread_id = target, qcnt 0.
    - Otherwise → IDLE, o_thread_id = target.
  - i_block is ignored in SWITCH.
- Reset asserted in any state (including mid-drain) returns all outputs to reset values on the next edge.

## Timing
- Event sampled at edge N → o_thread_valid 0 and o_switch 1 after edge N+1. Drain spans cycles N+1..N+SWITCH_CYCLES. The new o_thread_id and valid 1 appear after edge N+SWITCH_CYCLES+1.
- Timeout with no hold: a thread runs QUANTUM cycles, then the switch begins.
- A wake at edge W makes the thread eligible for scheduling decisions at edge W+1. From IDLE, a resume of cur has valid 1 after W+2.
- Simultaneous i_block on cur and i_wake[oth] at the same edge: oth is not yet runnable, so the scheduler goes to IDLE. It then switches to oth the following cycle.

## Test plan
- Reset, en=11, rst released → valid 1 on thread 0 one cycle after release. After 64 unheld cycles: o_switch pulse, 3 cycles with valid 0 and thread_id 0, then thread_id 1, valid 1.
- Thread 0 running, i_block at cycle 10, en=11 → o_blocked=01, drain, thread 1 runs. Later, i_wake[0] then thread 1 blocks → switch back to 0.
- Both blocked → IDLE with valid 0. Wake thread 1 → SWITCH (drain 3) then RUN on 1. Wake current thread instead → RUN with no o_switch.
- i_hold held high for 100 cycles at qcnt=63 → no switch and counter frozen. Release hold → switch starts the next cycle.
- en[1] dropped mid-drain toward thread 1 → ends in IDLE with thread_id 1, valid 0, o_blocked[1]=0.
- rst pulsed mid-drain → all outputs return to reset values on the next edge. The thread then restarts on thread 0.

Source files
------------

// File: rtl/thread_scheduler.sv
// Two-thread switch-on-event / quantum-timeout scheduler for the multithreaded MIPS core.
// Owns the register-file thread ID and holds it through a drain window after each switch.
module thread_scheduler #(
  parameter int QUANTUM       = 64,
  parameter int SWITCH_CYCLES = 3,
  parameter int QW            = $clog2(QUANTUM),
  parameter int SW            = $clog2(SWITCH_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_thread_en,
  input  logic       i_block,
  input  logic [1:0] i_wake,
  input  logic       i_hold,
  output logic       o_thread_id,
  output logic       o_thread_valid,
  output logic       o_switch,
  output logic       o_next_thread,
  output logic [1:0] o_blocked
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWITCH} state_t;

  state_t        r_state;
  logic [QW-1:0] r_qcnt;
  logic [SW-1:0] r_dcnt;

  logic       w_cur;
  logic       w_oth;
  logic [1:0] w_runnable;
  logic [1:0] w_set;
  logic [1:0] w_blocked_next;
  logic       w_qexp;

  assign w_cur  = o_thread_id;
  assign w_oth  = ~o_thread_id;
  assign w_qexp = (r_qcnt == QW'(QUANTUM - 1));

  // Set beats wake; a disabled thread is never left marked blocked.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_thread
      assign w_runnable[gi]     = i_thread_en[gi] & ~o_blocked[gi];
      assign w_set[gi]          = (r_state == ST_RUN) && i_block && (o_thread_id == 1'(gi));
      assign w_blocked_next[gi] = ~i_thread_en[gi] ? 1'b0 :
                                  w_set[gi]        ? 1'b1 :
                                  i_wake[gi]       ? 1'b0 : o_blocked[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_qcnt         <= '0;
      r_dcnt         <= '0;
      o_thread_id    <= 1'b0;
      o_thread_valid <= 1'b0;
      o_switch       <= 1'b0;
      o_next_thread  <= 1'b0;
      o_blocked      <= 2'b00;
    end else begin
      o_blocked <= w_blocked_next;
      o_switch  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_runnable[w_cur]) begin
            r_state        <= ST_RUN;
            r_qcnt         <= '0;
            o_thread_valid <= 1'b1;
            o_next_thread  <= w_cur;
          end else if (w_runnable[w_oth]) begin
            r_state        <= ST_SWITCH;
            r_dcnt         <= SW'(SWITCH_CYCLES);
            o_switch       <= 1'b1;
            o_thread_valid <= 1'b0;
            o_next_thread  <= w_oth;
          end
        end
        ST_RUN: begin
          if (i_block || !i_thread_en[w_cur]) begin
            o_thread_valid <= 1'b0;
            if (w_runnable[w_oth]) begin
              r_state       <= ST_SWITCH;
              r_dcnt        <= SW'(SWITCH_CYCLES);
              o_switch      <= 1'b1;
              o_next_thread <= w_oth;
            end else begin
              r_state       <= ST_IDLE;
              o_next_thread <= w_cur;
            end
          end else if (w_qexp && !i_hold && w_runnable[w_oth]) begin
            r_state        <= ST_SWITCH;
            r_dcnt         <= SW'(SWITCH_CYCLES);
            o_switch       <= 1'b1;
            o_thread_valid <= 1'b0;
            o_next_thread  <= w_oth;
          end else if (!i_hold && !w_qexp) begin
            r_qcnt <= r_qcnt + QW'(1);
          end
        end
        ST_SWITCH: begin
          // Old ID stays on o_thread_id until the drain finishes so late writebacks land correctly.
          if (r_dcnt == SW'(1)) begin
            o_thread_id <= o_next_thread;
            r_dcnt      <= '0;
            if (w_runnable[o_next_thread]) begin
              r_state        <= ST_RUN;
              r_qcnt         <= '0;
              o_thread_valid <= 1'b1;
            end else begin
              r_state        <= ST_IDLE;
              o_thread_valid <= 1'b0;
            end
          end else begin
            r_dcnt <= r_dcnt - SW'(1);
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          o_thread_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
